// File: rtl/ordenador_seq_pkg.sv
// Shared definitions for the sequential byte sorter: controller states and
// the legal range of burst depths.
package ordenador_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  // True when a burst depth can be handled by the index widths used here.
  function automatic bit depth_legal(input int d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/ordenador_seq_cmp.sv
// 8-bit unsigned tree comparator. Each bit produces a local greater/equal
// pair; pairs are merged MSB-first over three levels so that the higher
// half decides unless it is equal.
module ordenador_seq_cmp (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       m,  // a > b
  output logic       i   // a == b
);

  logic [7:0] g0, e0;
  logic [3:0] g1, e1;
  logic [1:0] g2, e2;

  // Leaf compare per bit, then three merge levels up the tree.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      g0[k] = a[k] & ~b[k];
      e0[k] = ~(a[k] ^ b[k]);
    end
    for (int k = 0; k < 4; k++) begin
      g1[k] = g0[2*k+1] | (e0[2*k+1] & g0[2*k]);
      e1[k] = e0[2*k+1] & e0[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      g2[k] = g1[2*k+1] | (e1[2*k+1] & g1[2*k]);
      e2[k] = e1[2*k+1] & e1[2*k];
    end
    m = g2[1] | (e2[1] & g2[0]);
    i = e2[1] & e2[0];
  end

endmodule

// File: rtl/ordenador_seq.sv
// Sequential bubble sorter: loads DEPTH bytes, orders them with a single
// time-shared tree comparator (one compare per cycle), then streams them
// out over a valid/ready handshake.
module ordenador_seq
  import ordenador_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit DESC  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CI = IW'(DEPTH - 2);
  localparam bit DEPTH_OK = depth_legal(DEPTH);

  if (!DEPTH_OK) begin : g_bad_depth
    $error("ordenador_seq: DEPTH must be within 2..8");
  end

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [IW-1:0] li, ci, di, pc;
  logic          sw;

  logic [IW-1:0] ci_nx;
  logic [7:0]    cmp_a, cmp_b;
  logic          cmp_m, cmp_i;
  logic          swap;

  // Comparator operands are the adjacent pair selected by the compare index.
  always_comb begin
    ci_nx = ci + ONE;
    cmp_a = mem[ci[AW-1:0]];
    cmp_b = mem[ci_nx[AW-1:0]];
  end

  ordenador_seq_cmp u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .m (cmp_m),
    .i (cmp_i)
  );

  // Equal bytes never swap, which keeps the ordering stable in both directions.
  always_comb begin
    swap = 1'b0;
    if (state == SORT)
      swap = DESC ? (!cmp_m && !cmp_i) : cmp_m;
  end

  // Output byte comes straight from the buffer at the drain index.
  always_comb out_data = mem[di[AW-1:0]];

  // Controller: load, bubble passes with early exit and pass cap, drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      li        <= '0;
      ci        <= '0;
      di        <= '0;
      pc        <= '0;
      sw        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            mem[li[AW-1:0]] <= in_data;
            if (li == LAST) begin
              li       <= '0;
              ci       <= '0;
              pc       <= '0;
              sw       <= 1'b0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              li <= li + ONE;
            end
          end
        end

        SORT: begin
          if (swap) begin
            mem[ci[AW-1:0]]    <= cmp_b;
            mem[ci_nx[AW-1:0]] <= cmp_a;
          end
          if (ci == LAST_CI) begin
            // A clean pass means the buffer is ordered; pc caps the pass count.
            ci <= '0;
            sw <= 1'b0;
            if ((!sw && !swap) || (pc == LAST)) begin
              pc        <= '0;
              di        <= '0;
              state     <= DRAIN;
              out_valid <= 1'b1;
            end else begin
              pc <= pc + ONE;
            end
          end else begin
            ci <= ci_nx;
            sw <= sw | swap;
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            if (di == LAST) begin
              di        <= '0;
              li        <= '0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              di <= di + ONE;
            end
          end
        end

        default: begin
          state     <= LOAD;
          li        <= '0;
          ci        <= '0;
          di        <= '0;
          pc        <= '0;
          sw        <= 1'b0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
